// File: rtl/sga_pkg.sv
// Shared SGA types: LED matrix geometry and the frame vector used by the top.
package sga_pkg;

    localparam int LED_ROWS = 6;
    localparam int LED_COLS = 6;
    localparam int LED_BITS = LED_ROWS * LED_COLS;

    typedef logic [LED_BITS-1:0] led_frame_t;

endpackage

// File: rtl/sga_pwm_gate.sv
// Brightness gate: column drive is allowed while (phase mod 8) <= level.
module sga_pwm_gate (
    input  logic [2:0] phase,
    input  logic [2:0] level,
    output logic       lit
);

    assign lit = ({1'b0, phase} < ({1'b0, level} + 4'd1));

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed, double-buffered 6x6 LED scanner with inter-row blanking.
// Optional SGA_BRIGHTNESS_PWM_EN adds a 3-bit brightness PWM on the columns.
module led_matrix_scanner
    import sga_pkg::*;
#(
    parameter int ROWS        = LED_ROWS,
    parameter int COLS        = LED_COLS,
    parameter int ROW_TICKS   = 2500,
    parameter int BLANK_TICKS = 50
) (
    input  logic               clock,
    input  logic               restart,
    input  logic               enable,
    input  logic [ROWS*COLS-1:0] frame,
    input  logic               frame_valid,
`ifdef SGA_BRIGHTNESS_PWM_EN
    input  logic [2:0]         brightness,
`endif
    output logic [ROWS-1:0]    row_sel,
    output logic [COLS-1:0]    col_data,
    output logic               frame_start,
    output logic [2:0]         db_row
);

    localparam int MAX_TICKS = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int CW = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    logic [1:0]           state, state_n;
    logic [2:0]           row, row_n;
    logic [CW-1:0]        count, count_n;
    logic [ROWS*COLS-1:0] shadow, shadow_n;
    logic [ROWS*COLS-1:0] pending;
    logic                 pending_flag;
    logic                 take;
    logic                 start_drive;
    logic [COLS-1:0]      row_bits;
    logic [COLS-1:0]      col_n;

    always_comb begin
        state_n = state;
        row_n   = row;
        count_n = count;
        take    = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            row_n   = '0;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = BLANK;
                    row_n   = '0;
                    count_n = '0;
                end
                BLANK: begin
                    if (count == CW'(BLANK_TICKS - 1)) begin
                        state_n = DRIVE;
                        count_n = '0;
                        take    = (row == 3'd0);
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
                DRIVE: begin
                    if (count == CW'(ROW_TICKS - 1)) begin
                        state_n = BLANK;
                        count_n = '0;
                        row_n   = (row == 3'(ROWS - 1)) ? 3'd0 : row + 3'd1;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    row_n   = '0;
                    count_n = '0;
                end
            endcase
        end
    end

    // Frame boundary swap; a strobe landing on the swap cycle bypasses pending.
    always_comb begin
        shadow_n = shadow;
        if (take) begin
            if (frame_valid) begin
                shadow_n = frame;
            end else if (pending_flag) begin
                shadow_n = pending;
            end
        end
    end

    assign start_drive = (state == BLANK) && (state_n == DRIVE);
    assign row_bits    = COLS'(shadow_n >> (row_n * COLS));

`ifdef SGA_BRIGHTNESS_PWM_EN
    logic [2:0] level, level_n;
    logic       lit;

    assign level_n = start_drive ? brightness : level;

    sga_pwm_gate u_pwm_gate (
        .phase (3'(count_n)),
        .level (level_n),
        .lit   (lit)
    );

    assign col_n = lit ? row_bits : '0;

    always_ff @(posedge clock) begin
        if (restart) begin
            level <= '0;
        end else begin
            level <= level_n;
        end
    end
`else
    assign col_n = row_bits;
`endif

    always_ff @(posedge clock) begin
        if (restart) begin
            state        <= IDLE;
            row          <= '0;
            count        <= '0;
            shadow       <= '0;
            pending      <= '0;
            pending_flag <= 1'b0;
            row_sel      <= '0;
            col_data     <= '0;
            frame_start  <= 1'b0;
            db_row       <= '0;
        end else begin
            state  <= state_n;
            row    <= row_n;
            count  <= count_n;
            shadow <= shadow_n;
            if (frame_valid) begin
                pending <= frame;
            end
            if (take) begin
                pending_flag <= 1'b0;
            end else if (frame_valid) begin
                pending_flag <= 1'b1;
            end
            row_sel     <= (state_n == DRIVE) ? (ROWS'(1) << row_n) : '0;
            col_data    <= (state_n == DRIVE) ? col_n : '0;
            frame_start <= start_drive && (row_n == 3'd0);
            db_row      <= row_n;
        end
    end

endmodule
